// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// control FSM states and a flag-packing helper.
package alu_pkg;

    localparam int OC_WIDTH = 3;

    localparam logic [OC_WIDTH-1:0] OC_SHL = 3'b000;
    localparam logic [OC_WIDTH-1:0] OC_XOR = 3'b001;
    localparam logic [OC_WIDTH-1:0] OC_AND = 3'b010;
    localparam logic [OC_WIDTH-1:0] OC_OR  = 3'b011;
    localparam logic [OC_WIDTH-1:0] OC_ADD = 3'b100;
    localparam logic [OC_WIDTH-1:0] OC_ADC = 3'b101;
    localparam logic [OC_WIDTH-1:0] OC_SUB = 3'b110;
    localparam logic [OC_WIDTH-1:0] OC_SBC = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                              input logic n, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/carry_ripple_adder.sv
// Plain ripple-carry adder: s_o = a_i + b_i + c_i, carry-out on c_o.
module carry_ripple_adder #(
    parameter int CRA_BIT_NUMB = 4
) (
    input  logic [CRA_BIT_NUMB-1:0] a_i,
    input  logic [CRA_BIT_NUMB-1:0] b_i,
    input  logic                    c_i,
    output logic [CRA_BIT_NUMB-1:0] s_o,
    output logic                    c_o
);

    logic [CRA_BIT_NUMB:0] w_c;

    assign w_c[0] = c_i;

    genvar gi;
    generate
        for (gi = 0; gi < CRA_BIT_NUMB; gi++) begin : g_bit
            assign s_o[gi]    = a_i[gi] ^ b_i[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (a_i[gi] & b_i[gi]) | (w_c[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign c_o = w_c[CRA_BIT_NUMB];

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready request handshake, persistent ZCNV flags,
// carry-chained ADC/SBC and an iterative one-bit-per-cycle left shift.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       oc_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o,
    output logic [3:0]       flags_o
);

    state_t                 r_state, w_next;
    logic [WIDTH-1:0]       r_result, r_work;
    logic [3:0]             r_flags;
    logic [SHAMT_WIDTH-1:0] r_cnt;

    logic [WIDTH-1:0]       w_b_eff, w_sum, w_res, w_sh;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic                   w_cin, w_cout, w_c, w_v, w_accept, w_long_shl;

    assign w_shamt    = b_i[SHAMT_WIDTH-1:0];
    assign w_accept   = valid_i && (r_state == ST_IDLE);
    assign w_long_shl = (oc_i == OC_SHL) && (w_shamt != '0);
    assign w_sh       = {r_work[WIDTH-2:0], 1'b0};

    // oc[1] selects subtraction (invert B); oc[0] selects the stored carry as carry-in.
    assign w_b_eff = oc_i[1] ? ~b_i : b_i;
    assign w_cin   = oc_i[0] ? r_flags[FLAG_C] : oc_i[1];

    carry_ripple_adder #(
        .CRA_BIT_NUMB (WIDTH)
    ) u_cra (
        .a_i (a_i),
        .b_i (w_b_eff),
        .c_i (w_cin),
        .s_o (w_sum),
        .c_o (w_cout)
    );

    always_comb begin
        w_res = '0;
        w_c   = r_flags[FLAG_C];
        w_v   = 1'b0;
        case (oc_i)
            OC_SHL: begin
                w_res = a_i;
                w_c   = 1'b0;
            end
            OC_XOR: w_res = a_i ^ b_i;
            OC_AND: w_res = a_i & b_i;
            OC_OR:  w_res = a_i | b_i;
            default: begin
                w_res = w_sum;
                w_c   = w_cout;
                w_v   = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = w_long_shl ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (r_cnt == SHAMT_WIDTH'(1)) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_result <= '0;
            r_flags  <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_long_shl) begin
                        r_work <= a_i;
                        r_cnt  <= w_shamt;
                    end else if (w_accept) begin
                        r_result <= w_res;
                        r_flags  <= pack_flags(w_res == '0, w_c, w_res[WIDTH-1], w_v);
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_sh;
                    r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
                    // Visible state only changes with the final shift.
                    if (r_cnt == SHAMT_WIDTH'(1)) begin
                        r_result <= w_sh;
                        r_flags  <= pack_flags(w_sh == '0, r_work[WIDTH-1], w_sh[WIDTH-1], 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (r_state == ST_IDLE);
    assign valid_o  = (r_state == ST_DONE);
    assign result_o = r_result;
    assign flags_o  = r_flags;

endmodule
